// File: rtl/reg_file_rename_pkg.sv
// reg_file_rename_pkg: shared widths, tag encoding and types for the renaming register file
package reg_file_rename_pkg;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int TAG_W      = 4;
    localparam int CNT_W      = 6;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [TAG_W-1:0]      tag_t;
    localparam tag_t TAG_NONE = '0;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one source lookup with x0 masking and optional CDB bypass (REG_FILE_CDB_BYPASS_EN)
module reg_file_read_port
    import reg_file_rename_pkg::*;
(
    input  reg_addr_t addr,
    input  xlen_t     st_data,
    input  logic      st_busy,
    input  tag_t      st_tag,
    input  logic      cdb_valid,
    input  tag_t      cdb_tag,
    input  xlen_t     cdb_data,
    input  logic      flush,
    output xlen_t     data,
    output logic      busy,
    output tag_t      tag
);
`ifdef REG_FILE_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic zero;
    logic hit;
    // x0 reads as constant zero; a pending producer broadcasting now may be forwarded
    always_comb begin
        zero = addr == '0;
        hit  = BYPASS && cdb_valid && !flush && st_busy && cdb_tag != TAG_NONE && st_tag == cdb_tag;
        data = zero ? '0 : hit ? cdb_data : st_data;
        busy = !zero && !hit && st_busy;
        tag  = (zero || hit) ? TAG_NONE : st_tag;
    end
endmodule

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with rename tags and CDB retirement (REG_FILE_CDB_BYPASS_EN)
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    output xlen_t            rs1_data,
    output logic             rs1_busy,
    output tag_t             rs1_tag,
    output xlen_t            rs2_data,
    output logic             rs2_busy,
    output tag_t             rs2_tag,
    input  logic             issue_valid,
    input  logic             rd_en,
    input  reg_addr_t        rd_addr,
    input  tag_t             rd_tag,
    input  logic             cdb_valid,
    input  tag_t             cdb_tag,
    input  xlen_t            cdb_data,
    input  logic             flush,
    output logic [CNT_W-1:0] pending_cnt
);
    xlen_t            data_q [NREG];
    xlen_t            data_d [NREG];
    tag_t             tag_q  [NREG];
    tag_t             tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    // Flush drops all renames; otherwise CDB retires matches, then a rename claims busy/tag
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        cnt_d  = '0;
        for (int i = 1; i < NREG; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = TAG_NONE;
            end else begin
                if (cdb_valid && cdb_tag != TAG_NONE && busy_q[i] && tag_q[i] == cdb_tag) begin
                    data_d[i] = cdb_data;
                    busy_d[i] = 1'b0;
                    tag_d[i]  = TAG_NONE;
                end
                if (issue_valid && rd_en && rd_addr == reg_addr_t'(i)) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = rd_tag;
                end
            end
        end
        for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
    // State registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_NONE;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
    assign pending_cnt = cnt_q;
    // A real rename must carry an allocated tag
    assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && rd_en && rd_addr != '0 && rd_tag == TAG_NONE));
    reg_file_read_port u_rs1 (
        .addr(rs1_addr), .st_data(data_q[rs1_addr]), .st_busy(busy_q[rs1_addr]), .st_tag(tag_q[rs1_addr]),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
        .data(rs1_data), .busy(rs1_busy), .tag(rs1_tag)
    );
    reg_file_read_port u_rs2 (
        .addr(rs2_addr), .st_data(data_q[rs2_addr]), .st_busy(busy_q[rs2_addr]), .st_tag(tag_q[rs2_addr]),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
        .data(rs2_data), .busy(rs2_busy), .tag(rs2_tag)
    );
endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: directed checks of rename, CDB retirement, x0, collision, bypass, flush and async reset
module tb_reg_file_rename;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs2_data;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic        issue_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [3:0]  rd_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        flush = 1'b0;
    logic [5:0]  pending_cnt;
    int errors = 0;
    int checks = 0;

    reg_file_rename dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_data(rs2_data), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .issue_valid(issue_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [3:0] t);
        issue_valid = 1'b1;
        rd_en = 1'b1;
        rd_addr = a;
        rd_tag = t;
        tick();
        issue_valid = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic bcast(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag = t;
        cdb_data = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rs1_addr = 5;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_read: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h0, 1'b0, 4'd0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", pending_cnt);
        end
    endtask

    task automatic test_rename_cdb();
        rs1_addr = 3;
        issue(3, 4);
        checks++;
        if ({rs1_busy, rs1_tag} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL rename_x3: got %h expected %h", {rs1_busy, rs1_tag}, {1'b1, 4'd4});
        end
        checks++;
        if (pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL rename_cnt: got %0d expected 1", pending_cnt);
        end
        bcast(4, 32'hDEADBEEF);
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL cdb_x3: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'hDEADBEEF, 1'b0, 4'd0});
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL cdb_cnt: got %0d expected 0", pending_cnt);
        end
    endtask

    task automatic test_x0();
        rs1_addr = 0;
        issue(0, 2);
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL x0_rename: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h0, 1'b0, 4'd0});
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL x0_cnt: got %0d expected 0", pending_cnt);
        end
        bcast(2, 32'h55);
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL x0_cdb: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h0, 1'b0, 4'd0});
        end
    endtask

    task automatic test_collision();
        rs1_addr = 3;
        rs2_addr = 7;
        issue(3, 4);
        issue(7, 4);
        checks++;
        if (pending_cnt !== 6'd2) begin
            errors++;
            $display("FAIL coll_cnt_pre: got %0d expected 2", pending_cnt);
        end
        issue_valid = 1'b1;
        rd_en = 1'b1;
        rd_addr = 3;
        rd_tag = 5;
        cdb_valid = 1'b1;
        cdb_tag = 4;
        cdb_data = 32'h11;
        tick();
        issue_valid = 1'b0;
        rd_en = 1'b0;
        cdb_valid = 1'b0;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h11, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL coll_x3: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h11, 1'b1, 4'd5});
        end
        checks++;
        if ({rs2_data, rs2_busy, rs2_tag} !== {32'h11, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL coll_x7: got %h expected %h", {rs2_data, rs2_busy, rs2_tag}, {32'h11, 1'b0, 4'd0});
        end
        checks++;
        if (pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL coll_cnt: got %0d expected 1", pending_cnt);
        end
        bcast(5, 32'h99);
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h99, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL coll_retire: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h99, 1'b0, 4'd0});
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL coll_cnt_post: got %0d expected 0", pending_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [36:0] exp;
        rs1_addr = 3;
        rs2_addr = 8;
        issue(3, 4);
        cdb_valid = 1'b1;
        cdb_tag = 4;
        cdb_data = 32'h22;
        #1;
`ifdef REG_FILE_CDB_BYPASS_EN
        exp = {32'h22, 1'b0, 4'd0};
`else
        exp = {32'h99, 1'b1, 4'd4};
`endif
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== exp) begin
            errors++;
            $display("FAIL bypass_x3: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, exp);
        end
        checks++;
        if ({rs2_data, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL bypass_x8: got %h expected %h", {rs2_data, rs2_busy, rs2_tag}, {32'h0, 1'b0, 4'd0});
        end
        tick();
        cdb_valid = 1'b0;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h22, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL bypass_stored: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h22, 1'b0, 4'd0});
        end
    endtask

    task automatic test_flush();
        rs1_addr = 1;
        rs2_addr = 2;
        issue(1, 6);
        bcast(6, 32'hA5A5);
        issue(1, 1);
        issue(2, 2);
        issue(9, 3);
        checks++;
        if (pending_cnt !== 6'd3) begin
            errors++;
            $display("FAIL flush_cnt_pre: got %0d expected 3", pending_cnt);
        end
        flush = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag = 1;
        cdb_data = 32'h77;
        #1;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'hA5A5, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL flush_nobypass: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'hA5A5, 1'b1, 4'd1});
        end
        tick();
        flush = 1'b0;
        cdb_valid = 1'b0;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'hA5A5, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_x1: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'hA5A5, 1'b0, 4'd0});
        end
        checks++;
        if ({rs2_data, rs2_busy, rs2_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_x2: got %h expected %h", {rs2_data, rs2_busy, rs2_tag}, {32'h0, 1'b0, 4'd0});
        end
        rs2_addr = 9;
        #1;
        checks++;
        if ({rs2_busy, rs2_tag} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_x9: got %h expected %h", {rs2_busy, rs2_tag}, {1'b0, 4'd0});
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL flush_cnt: got %0d expected 0", pending_cnt);
        end
    endtask

    task automatic test_async_reset();
        rs1_addr = 4;
        rs2_addr = 1;
        issue(4, 7);
        checks++;
        if (pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL areset_cnt_pre: got %0d expected 1", pending_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rs1_data, rs1_busy, rs1_tag} !== {32'h0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL areset_x4: got %h expected %h", {rs1_data, rs1_busy, rs1_tag}, {32'h0, 1'b0, 4'd0});
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL areset_x1: got %h expected 0", rs2_data);
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL areset_cnt: got %0d expected 0", pending_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rename_cdb();
        test_x0();
        test_collision();
        test_bypass();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
